// File: rtl/rram_imc_seq.sv
`default_nettype none
// ============================================================================
// rram_imc_seq : bus-programmable READ / MAC / SET / RESET sequencer for the
//                RRAM in-memory-compute macro.
// Revision     : 1.0
// ============================================================================
module rram_imc_seq #(
  parameter int ROWS      = 16,
  parameter int COLS      = 16,
  parameter int ADC_BITS  = 3,
  parameter int ACC_W     = 8,
  parameter int PRE_CYC   = 4,
  parameter int SENSE_CYC = 2,
  parameter int PULSE_CYC = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [31:0]         wishbone_address_bus,
  input  logic [31:0]         wishbone_data_in,
  output logic [31:0]         wishbone_data_out,
  output logic                wbs_ack_o,
  input  logic                enable_IM,
  input  logic [COLS-1:0]     CSA,
  input  logic [ADC_BITS-1:0] adc_in,
  output logic [ROWS-1:0]     wl_en,
  output logic [COLS-1:0]     bl_sel,
  output logic                sl_sel,
  output logic                pre_en,
  output logic                csa_en,
  output logic                adc_sample,
  output logic                busy
);

  localparam int CNT_MAX_PS = (PRE_CYC > SENSE_CYC) ? PRE_CYC : SENSE_CYC;
  localparam int CNT_MAX    = (PULSE_CYC > CNT_MAX_PS) ? PULSE_CYC : CNT_MAX_PS;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int COL_W      = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [1:0] MODE_READ  = 2'b00;
  localparam logic [1:0] MODE_MAC   = 2'b01;
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_ROW    = 2'd1;
  localparam logic [1:0] REG_COL    = 2'd2;
  localparam logic [1:0] REG_RESULT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_SENSE = 3'd2,
    ST_NEXT  = 3'd3,
    ST_PULSE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [COLS-1:0]  csa_q, csa_d;
  logic [1:0]       mode_q;
  logic [ROWS-1:0]  row_mask_q;
  logic [COLS-1:0]  col_mask_q;
  logic             done_q, err_q, ack_q;
  logic [31:0]      rdata_q;

  logic             w_xfer, w_wr, w_idle, w_start_req, w_start_ok;
  logic [1:0]       w_sel, w_start_mode;
  logic             w_pre_last, w_sense_last, w_pulse_last, w_col_last;
  logic [COLS-1:0]  w_col_onehot;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_acc_sat;
  logic [31:0]      w_rdata;
  logic             w_unused_bits;

  // A strobe seen during the ack cycle belongs to the transfer being acked.
  assign w_xfer       = wbs_stb_i & ~ack_q;
  assign w_wr         = w_xfer & wbs_we_i;
  assign w_sel        = wishbone_address_bus[3:2];
  assign w_idle       = (state_q == ST_IDLE);
  assign w_start_req  = w_wr & (w_sel == REG_CTRL) & wishbone_data_in[0] & w_idle;
  assign w_start_ok   = w_start_req & enable_IM & (|row_mask_q);
  assign w_start_mode = wishbone_data_in[2:1];
  assign w_unused_bits = ^{wishbone_address_bus[31:4], wishbone_address_bus[1:0], wishbone_data_in};

  assign w_pre_last   = (cnt_q == CNT_W'(PRE_CYC - 1));
  assign w_sense_last = (cnt_q == CNT_W'(SENSE_CYC - 1));
  assign w_pulse_last = (cnt_q == CNT_W'(PULSE_CYC - 1));
  assign w_col_last   = (col_q == COL_W'(COLS - 1));
  assign w_col_onehot = COLS'(1) << col_q;

  assign w_sum     = {1'b0, acc_q} + (ACC_W + 1)'(adc_in);
  assign w_acc_sat = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];

  assign busy              = ~w_idle;
  assign wbs_ack_o         = ack_q;
  assign wishbone_data_out = rdata_q;

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      REG_CTRL:   w_rdata = {26'd0, err_q, done_q, busy, mode_q, 1'b0};
      REG_ROW:    w_rdata = 32'(row_mask_q);
      REG_COL:    w_rdata = 32'(col_mask_q);
      REG_RESULT: w_rdata = (mode_q == MODE_MAC) ? 32'(acc_q) : 32'(csa_q);
      default:    w_rdata = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    col_d      = col_q;
    acc_d      = acc_q;
    csa_d      = csa_q;
    wl_en      = '0;
    bl_sel     = '0;
    sl_sel     = 1'b0;
    pre_en     = 1'b0;
    csa_en     = 1'b0;
    adc_sample = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (w_start_ok) begin
          cnt_d = '0;
          col_d = '0;
          if (w_start_mode == MODE_READ) begin
            state_d = ST_PRE;
          end else if (w_start_mode == MODE_MAC) begin
            state_d = ST_NEXT;
            acc_d   = '0;
          end else begin
            state_d = ST_PULSE;
          end
        end
      end
      ST_PRE: begin
        pre_en = 1'b1;
        if (w_pre_last) begin
          cnt_d   = '0;
          state_d = ST_SENSE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SENSE: begin
        wl_en      = row_mask_q;
        csa_en     = 1'b1;
        bl_sel     = (mode_q == MODE_MAC) ? w_col_onehot : '1;
        adc_sample = (mode_q == MODE_MAC) & w_sense_last;
        if (w_sense_last) begin
          cnt_d = '0;
          if (mode_q == MODE_MAC) begin
            acc_d = w_acc_sat;
            if (w_col_last) begin
              state_d = ST_DONE;
            end else begin
              col_d   = col_q + COL_W'(1);
              state_d = ST_NEXT;
            end
          end else begin
            csa_d   = CSA;
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_NEXT: begin
        if (col_mask_q[col_q]) begin
          cnt_d   = '0;
          state_d = ST_PRE;
        end else if (w_col_last) begin
          state_d = ST_DONE;
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      ST_PULSE: begin
        wl_en  = row_mask_q;
        bl_sel = col_mask_q;
        sl_sel = mode_q[0];
        if (w_pulse_last) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort wins over everything, including a capture due on this edge.
    if (!w_idle && !enable_IM) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      acc_d   = acc_q;
      csa_d   = csa_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      col_q      <= '0;
      acc_q      <= '0;
      csa_q      <= '0;
      mode_q     <= MODE_READ;
      row_mask_q <= '0;
      col_mask_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      csa_q   <= csa_d;
      ack_q   <= w_xfer;
      if (w_xfer) rdata_q <= w_rdata;
      if (w_wr && w_idle) begin
        case (w_sel)
          REG_CTRL: mode_q     <= wishbone_data_in[2:1];
          REG_ROW:  row_mask_q <= wishbone_data_in[ROWS-1:0];
          REG_COL:  col_mask_q <= wishbone_data_in[COLS-1:0];
          default:  ;
        endcase
      end
      if (w_start_req) begin
        done_q <= 1'b0;
        err_q  <= ~(enable_IM & (|row_mask_q));
      end else begin
        if (state_q == ST_DONE && enable_IM) done_q <= 1'b1;
        if (!w_idle && !enable_IM) err_q <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rram_imc_seq.sv
`default_nettype none
// ============================================================================
// tb_rram_imc_seq : directed plus randomized checks of rram_imc_seq against a
//                   cycle-count / arithmetic reference model.
// Revision        : 1.0
// ============================================================================
module tb_rram_imc_seq;
  localparam int COLS  = 16;
  localparam int PRE   = 4;
  localparam int SENSE = 2;
  localparam int PULSE = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        en = 1'b1;
  logic [15:0] csa = '0;
  logic [2:0]  adc = '0;

  logic [31:0] dout_a, dout_b;
  logic        ack_a, ack_b, sl_a, sl_b, pre_a, pre_b, csaen_a, csaen_b;
  logic        samp_a, samp_b, busy_a, busy_b;
  logic [15:0] wl_a, wl_b, bl_a, bl_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rram_imc_seq dut_a (
    .clk(clk), .rst(rst), .wbs_stb_i(stb), .wbs_we_i(we),
    .wishbone_address_bus(addr), .wishbone_data_in(wdata),
    .wishbone_data_out(dout_a), .wbs_ack_o(ack_a), .enable_IM(en),
    .CSA(csa), .adc_in(adc), .wl_en(wl_a), .bl_sel(bl_a), .sl_sel(sl_a),
    .pre_en(pre_a), .csa_en(csaen_a), .adc_sample(samp_a), .busy(busy_a)
  );

  rram_imc_seq #(.ACC_W(4)) dut_b (
    .clk(clk), .rst(rst), .wbs_stb_i(stb), .wbs_we_i(we),
    .wishbone_address_bus(addr), .wishbone_data_in(wdata),
    .wishbone_data_out(dout_b), .wbs_ack_o(ack_b), .enable_IM(en),
    .CSA(csa), .adc_in(adc), .wl_en(wl_b), .bl_sel(bl_b), .sl_sel(sl_b),
    .pre_en(pre_b), .csa_en(csaen_b), .adc_sample(samp_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns in the ack cycle, i.e. #1 after the capture edge.
  task automatic bus(input logic w, input logic [1:0] sel, input logic [31:0] d,
                     output logic [31:0] ra, output logic [31:0] rb);
    @(posedge clk); #1;
    stb = 1'b1; we = w; addr = {28'd0, sel, 2'b00}; wdata = d;
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0;
    chk("ack_a", {31'd0, ack_a}, 32'd1);
    chk("ack_b", {31'd0, ack_b}, 32'd1);
    ra = dout_a;
    rb = dout_b;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] d);
    logic [31:0] ra, rb;
    bus(1'b1, sel, d, ra, rb);
  endtask

  task automatic run_op(input logic [1:0] mode, input logic [15:0] row, input logic [15:0] col,
                        input logic [15:0] cv, input logic [2:0] av);
    int L, pre_n, sense_n, samp_n, pulse_n, first_sense, wl_bad, lock_bad, n, sum;
    int exp_L, exp_pre, exp_sense, exp_samp, exp_pulse;
    logic [15:0] samp_or, last_bl;
    logic        order_ok;
    logic [31:0] ra, rb;
    L = -1; pre_n = 0; sense_n = 0; samp_n = 0; pulse_n = 0; first_sense = -1;
    wl_bad = 0; lock_bad = 0; samp_or = '0; last_bl = '0; order_ok = 1'b1;
    wr(2'd1, {16'd0, row});
    wr(2'd2, {16'd0, col});
    csa = cv; adc = av;
    bus(1'b1, 2'd0, {29'd0, mode, 1'b1}, ra, rb);
    for (int j = 0; j < 400; j++) begin
      if (!busy_a) begin L = j; break; end
      if (pre_a) pre_n++;
      if (csaen_a) begin
        sense_n++;
        if (first_sense < 0) first_sense = j;
        if (wl_a !== row) wl_bad++;
      end
      if (samp_a) begin
        samp_n++;
        if (!$onehot(bl_a) || bl_a <= last_bl) order_ok = 1'b0;
        last_bl = bl_a;
        samp_or = samp_or | bl_a;
      end
      if (wl_a === row && bl_a === col && sl_a === mode[0] && !pre_a && !csaen_a) pulse_n++;
      if ({wl_a, bl_a, sl_a, pre_a, csaen_a, samp_a, busy_a} !==
          {wl_b, bl_b, sl_b, pre_b, csaen_b, samp_b, busy_b}) lock_bad++;
      @(posedge clk); #1;
    end
    n = $countones(col);
    sum = n * int'(av);
    exp_pre = 0; exp_sense = 0; exp_samp = 0; exp_pulse = 0;
    if (mode == 2'b00) begin
      exp_L = PRE + SENSE + 1; exp_pre = PRE; exp_sense = SENSE;
    end else if (mode == 2'b01) begin
      exp_L = COLS + n * (PRE + SENSE) + 1; exp_pre = n * PRE; exp_sense = n * SENSE; exp_samp = n;
    end else begin
      exp_L = PULSE + 1; exp_pulse = PULSE;
    end
    chk("latency", L, exp_L);
    chk("pre_cycles", pre_n, exp_pre);
    chk("sense_cycles", sense_n, exp_sense);
    chk("adc_samples", samp_n, exp_samp);
    chk("pulse_cycles", pulse_n, exp_pulse);
    chk("wl_during_sense", wl_bad, 0);
    chk("dut_lockstep", lock_bad, 0);
    chk("idle_drives", {8'd0, wl_a | bl_a, sl_a, pre_a, csaen_a, samp_a, 4'd0}, 32'd0);
    if (mode == 2'b00) chk("first_sense", first_sense, PRE);
    if (mode == 2'b01) begin
      chk("sample_cols", {16'd0, samp_or}, {16'd0, col});
      chk("sample_order", {31'd0, order_ok}, 32'd1);
    end
    bus(1'b0, 2'd0, 32'd0, ra, rb);
    chk("ctrl_done", ra, {26'd0, 1'b0, 1'b1, 1'b0, mode, 1'b0});
    if (mode == 2'b00 || mode == 2'b01) begin
      bus(1'b0, 2'd3, 32'd0, ra, rb);
      if (mode == 2'b00) begin
        chk("result_read_a", ra, {16'd0, cv});
        chk("result_read_b", rb, {16'd0, cv});
      end else begin
        chk("result_mac_a", ra, (sum > 255) ? 32'd255 : 32'(sum));
        chk("result_mac_b", rb, (sum > 15) ? 32'd15 : 32'(sum));
      end
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    // Reset and register readback.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_drives", {8'd0, wl_a | bl_a, sl_a, pre_a, csaen_a, samp_a, busy_a, ack_a, 2'd0}, 32'd0);
    for (int r = 0; r < 4; r++) begin
      bus(1'b0, 2'(r), 32'd0, ra, rb);
      chk("reset_reg_a", ra, 32'd0);
      chk("reset_reg_b", rb, 32'd0);
      @(posedge clk); #1;
      chk("ack_one_cycle", {31'd0, ack_a}, 32'd0);
    end
    // Strobe held through the ack cycle is not a second transfer.
    @(posedge clk); #1;
    stb = 1'b1; we = 1'b0; addr = 32'h0;
    @(posedge clk); #1;
    chk("held_ack1", {31'd0, ack_a}, 32'd1);
    @(posedge clk); #1;
    chk("held_ack2", {31'd0, ack_a}, 32'd0);
    stb = 1'b0;

    // Directed operations.
    run_op(2'b00, 16'h0005, 16'h0000, 16'hA5C3, 3'd0);
    run_op(2'b01, 16'h0001, 16'h0003, 16'h0000, 3'd7);
    run_op(2'b01, 16'h0001, 16'hFFFF, 16'h0000, 3'd7);
    run_op(2'b11, 16'h8000, 16'h0010, 16'h0000, 3'd0);
    run_op(2'b10, 16'h00FF, 16'h0F00, 16'h0000, 3'd0);

    // Randomized operations.
    for (int i = 0; i < 8; i++) begin
      run_op(2'($urandom_range(0, 3)), 16'($urandom_range(1, 65535)), 16'($urandom),
             16'($urandom), 3'($urandom_range(0, 7)));
    end

    // Mask writes while busy are ignored.
    wr(2'd1, 32'h0F0F);
    bus(1'b1, 2'd0, 32'h5, ra, rb);
    wr(2'd1, 32'h1234);
    for (int k = 0; k < 50 && busy_a; k++) begin
      @(posedge clk); #1;
    end
    chk("busy_cleared", {31'd0, busy_a}, 32'd0);
    bus(1'b0, 2'd1, 32'd0, ra, rb);
    chk("row_write_while_busy", ra, 32'h0F0F);

    // Abort in the second SENSE cycle of a READ.
    wr(2'd1, 32'h0005);
    bus(1'b1, 2'd0, 32'h1, ra, rb);
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("abort_in_sense", {31'd0, csaen_a}, 32'd1);
    en = 1'b0;
    @(posedge clk); #1;
    chk("abort_drives", {8'd0, wl_a | bl_a, sl_a, pre_a, csaen_a, samp_a, busy_a, 3'd0}, 32'd0);
    en = 1'b1;
    bus(1'b0, 2'd0, 32'd0, ra, rb);
    chk("abort_status", ra, 32'h20);

    // Start with ROW_MASK = 0 only flags an error.
    wr(2'd1, 32'h0);
    bus(1'b1, 2'd0, 32'h1, ra, rb);
    chk("zero_row_busy", {31'd0, busy_a}, 32'd0);
    @(posedge clk); #1;
    chk("zero_row_busy2", {31'd0, busy_a}, 32'd0);
    bus(1'b0, 2'd0, 32'd0, ra, rb);
    chk("zero_row_status", ra, 32'h20);

    // Clear err with a good op, then start with enable_IM low.
    run_op(2'b10, 16'h0001, 16'h0001, 16'h0000, 3'd0);
    en = 1'b0;
    bus(1'b1, 2'd0, 32'h1, ra, rb);
    chk("disabled_busy", {31'd0, busy_a}, 32'd0);
    en = 1'b1;
    bus(1'b0, 2'd0, 32'd0, ra, rb);
    chk("disabled_err", ra & 32'h28, 32'h20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rram_imc_seq.md
# rram_imc_seq

Parametrised, bus-programmable sequencer for the RRAM in-memory-compute macro. It generalises the fixed 16-column, 3-bit-ADC top level into a block sized by parameters. It drives the word-line, bit-line, source-line, precharge, CSA and ADC-sample controls for four modes: READ, MAC, SET and RESET. It sits between the Wishbone slave decode and the analog array/ADC pins; status and results are read back over the same bus.

## Interface
- ROWS, 16, word lines driven
- COLS, 16, bit-line/CSA columns
- ADC_BITS, 3, ADC code width
- ACC_W, 8, MAC accumulator width (≥ ADC_BITS+1)
- PRE_CYC, 4, precharge cycles (≥1)
- SENSE_CYC, 2, sense cycles (≥1)
- PULSE_CYC, 8, SET/RESET pulse cycles (≥1)

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- wbs_stb_i  in  1  bus strobe
- wbs_we_i  in  1  write enable
- wishbone_address_bus  in  32  byte address; bits [3:2] select the register
- wishbone_data_in  in  32  write data
- wishbone_data_out  out  32  registered read data
- wbs_ack_o  out  1  one-cycle acknowledge
- enable_IM  in  1  macro enable; low aborts and blocks start
- CSA  in  COLS  sense-amp digital outputs
- adc_in  in  ADC_BITS  ADC code
- wl_en  out  ROWS  word-line enables
- bl_sel  out  COLS  bit-line selects
- sl_sel  out  1  source-line polarity (1 = RESET)
- pre_en  out  1  bit-line precharge
- csa_en  out  1  CSA enable
- adc_sample  out  1  ADC sample strobe
- busy  out  1  operation in progress

## Operation
- Registers:
  - 0x0 CTRL: bit0 start (write-1, self-clearing); [2:1] mode (00 READ, 01 MAC, 10 SET, 11 RESET). Read-only status: bit3 busy, bit4 done (sticky, cleared by start), bit5 err (sticky, cleared by start).
  - 0x4 ROW_MASK: ROWS bits.
  - 0x8 COL_MASK: COLS bits.
  - 0xC RESULT: read-only; READ gives the captured CSA vector, MAC gives the accumulator, zero-extended.
- Writes to 0x4, 0x8 or 0xC while busy are acked and ignored. A start while busy is ignored.
- A start with enable_IM low, or with ROW_MASK = 0, sets err, leaves the FSM in IDLE, and does not set done.
- FSM states: IDLE, PRE, SENSE, NEXT, PULSE, DONE.
- READ: PRE for PRE_CYC cycles (pre_en=1), then SENSE for SENSE_CYC cycles (wl_en=ROW_MASK, bl_sel=all ones, csa_en=1). CSA is captured into RESULT on the last SENSE edge. Then DONE.
- MAC:
  - The accumulator clears at start. The column index c runs from 0 to COLS-1.
  - Each column spends 1 NEXT cycle.
  - If COL_MASK[c] is set, that column also runs PRE then SENSE with bl_sel one-hot at c. adc_sample=1 in the last SENSE cycle, and acc ← min(acc+adc_in, 2^ACC_W−1) on that edge.
  - After c = COLS-1, go to DONE.
- SET/RESET: PULSE for PULSE_CYC cycles (wl_en=ROW_MASK, bl_sel=COL_MASK, sl_sel=mode[0]), then DONE.
- DONE (1 cycle): all drives are 0 and done←1. Next state is IDLE.
- Outside their active states, wl_en, bl_sel, sl_sel, pre_en, csa_en and adc_sample are 0.
- Abort: enable_IM low in any non-IDLE state → IDLE on the next edge, all drives 0 from that edge, err←1, done unchanged, RESULT holds its partial value.

## Timing
- Reset values: all outputs 0; registers, accumulator and RESULT 0; FSM in IDLE.
- rst asserted mid-operation takes effect at the next edge.
- Bus:
  - A transfer with stb high is captured at edge T.
  - wbs_ack_o is high for the cycle after T, with wishbone_data_out valid in that cycle.
  - One transfer per two cycles: stb held high during the ack cycle is not a new transfer.
- Start: FSM leaves IDLE at the capture edge T. busy is high from that edge through the DONE cycle. done=1 is visible in the cycle after DONE.
- Latency from T to done visible:
  - READ: PRE_CYC+SENSE_CYC+1 (7 at defaults).
  - MAC: COLS + n_sel·(PRE_CYC+SENSE_CYC) + 1.
  - SET/RESET: PULSE_CYC+1.
- The accumulator saturates and never wraps.
- An ADC sample taken on the same edge as an abort is discarded.

## Test plan
- Reset, then read all four registers → every readback is 0, wbs_ack_o=1 exactly one cycle after each strobe, busy=0.
- ROW_MASK=0x0005, READ start, CSA=0xA5C3 during SENSE → wl_en=0x0005 for 2 cycles after 4 pre_en cycles; RESULT=0x0000A5C3; done visible at T+7.
- MAC with COL_MASK=0x0003 and adc_in=7 → two adc_sample pulses, bl_sel=0x0001 then 0x0002, RESULT=14, done visible at T+16+12+1.
- MAC with ACC_W=4 and COL_MASK=0xFFFF, adc_in=7 → RESULT saturates at 15 with no wrap.
- RESET mode with ROW_MASK=0x8000 and COL_MASK=0x0010 → for 8 cycles wl_en=0x8000, bl_sel=0x0010, sl_sel=1; done visible at T+9.
- Drop enable_IM in the 2nd SENSE cycle of a READ → drives go to 0 on the next edge, err=1, done=0, busy=0; a new start with ROW_MASK=0 sets err only.
